// File: rtl/prime_sched_pkg.sv
// Shared types and constants for the prime test scheduler and its trial-division engine.
package prime_sched_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, TEST, DONE} state_t;

   typedef struct packed {
      logic trivial;
      logic prime;
   } triv_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int CAND_START    = 5;
   localparam int CAND_STEP     = 6;

   // Operands that need no trial division: 0, 1, 2, 3 and multiples of 2 or 3.
   function automatic triv_t classify_trivial(input logic [63:0] n);
      triv_t r;
      r = '{trivial: 1'b0, prime: 1'b0};
      if (n <= 64'd1) begin
         r = '{trivial: 1'b1, prime: 1'b0};
      end else if (n == 64'd2 || n == 64'd3) begin
         r = '{trivial: 1'b1, prime: 1'b1};
      end else if (!n[0] || (n % 64'd3) == 64'd0) begin
         r = '{trivial: 1'b1, prime: 1'b0};
      end
      return r;
   endfunction

endpackage

// File: rtl/prime_test_scheduler_if.sv
// Request/response bundle between clients and the prime test scheduler.
// Optional rsp_cycles field exists only when PRIME_CYCLE_COUNT_EN is defined.
interface prime_test_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int ID_W    = $clog2(NUM_REQ)
) ();
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_num;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_num;
   logic                     rsp_is_prime;
`ifdef PRIME_CYCLE_COUNT_EN
   logic [WIDTH-1:0]         rsp_cycles;

   modport master (output req_valid, req_num, rsp_ready,
                   input  req_ready, rsp_valid, rsp_id, rsp_num, rsp_is_prime, rsp_cycles);
   modport slave  (input  req_valid, req_num, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_num, rsp_is_prime, rsp_cycles);
`else
   modport master (output req_valid, req_num, rsp_ready,
                   input  req_ready, rsp_valid, rsp_id, rsp_num, rsp_is_prime);
   modport slave  (input  req_valid, req_num, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_num, rsp_is_prime);
`endif
endinterface

// File: rtl/prime_trial_engine.sv
// Iterative 6k+-1 trial divider: tests one candidate pair (i, i+2) per cycle after start.
module prime_trial_engine import prime_sched_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] num,
   output logic             done,
   output logic             is_prime
);
   logic             busy;
   logic [WIDTH:0]   i, ip2, num_x;
   logic [2*WIDTH-1:0] sq;
   logic             past, hit;

   assign num_x = {1'b0, num};
   assign ip2   = i + (WIDTH+1)'(2);
   // Square at double width so it never wraps for any reachable i.
   assign sq    = {{WIDTH{1'b0}}, i[WIDTH-1:0]} * {{WIDTH{1'b0}}, i[WIDTH-1:0]};
   assign past  = sq > {{WIDTH{1'b0}}, num};
   assign hit   = ((num_x % i) == '0) || ((num_x % ip2) == '0);

   assign done     = busy && (past || hit);
   assign is_prime = past;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         i    <= (WIDTH+1)'(CAND_START);
      end else if (start) begin
         busy <= 1'b1;
         i    <= (WIDTH+1)'(CAND_START);
      end else if (busy) begin
         if (done) busy <= 1'b0;
         else      i    <= i + (WIDTH+1)'(CAND_STEP);
      end
   end
endmodule

// File: rtl/prime_test_scheduler.sv
// Round-robin front end sharing one prime_trial_engine among NUM_REQ requesters.
// Define PRIME_CYCLE_COUNT_EN to add the rsp_cycles TEST-cycle counter.
module prime_test_scheduler import prime_sched_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   prime_test_scheduler_if.slave bus
);
   state_t           state, state_nx;
   logic [ID_W-1:0]  last_grant, grant_idx, id_q;
   logic             grant_vld;
   logic [WIDTH-1:0] num_q;
   logic             prime_q;
   triv_t            triv;
   logic             eng_start, eng_done, eng_prime;
   int               idx;

   // Search starts just after the last winner so every waiting requester gets a turn.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int o = 1; o <= NUM_REQ; o++) begin
         idx = (int'(last_grant) + o) % NUM_REQ;
         if (!grant_vld && bus.req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
   end

   assign bus.req_ready = (state == IDLE && grant_vld) ? (NUM_REQ'(1) << grant_idx) : '0;
   assign triv          = classify_trivial(64'(num_q));
   assign eng_start     = (state == LOAD) && !triv.trivial;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (grant_vld) state_nx = LOAD;
         LOAD: state_nx = triv.trivial ? DONE : TEST;
         TEST: if (eng_done) state_nx = DONE;
         DONE: if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= ID_W'(NUM_REQ - 1);
         num_q      <= '0;
         id_q       <= '0;
         prime_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && grant_vld) begin
            num_q      <= bus.req_num[grant_idx*WIDTH +: WIDTH];
            id_q       <= grant_idx;
            last_grant <= grant_idx;
         end
         if (state == LOAD && triv.trivial) prime_q <= triv.prime;
         if (state == TEST && eng_done)     prime_q <= eng_prime;
      end
   end

   prime_trial_engine #(.WIDTH(WIDTH)) u_engine (
      .clk      (clk),
      .rst      (rst),
      .start    (eng_start),
      .num      (num_q),
      .done     (eng_done),
      .is_prime (eng_prime)
   );

   assign bus.rsp_valid    = (state == DONE);
   assign bus.rsp_id       = id_q;
   assign bus.rsp_num      = num_q;
   assign bus.rsp_is_prime = prime_q;

`ifdef PRIME_CYCLE_COUNT_EN
   logic [WIDTH-1:0] cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycles_q <= '0;
      end else if (state == LOAD) begin
         cycles_q <= '0;
      end else if (state == TEST && !(&cycles_q)) begin
         cycles_q <= cycles_q + WIDTH'(1);
      end
   end

   assign bus.rsp_cycles = cycles_q;
`endif
endmodule

// File: tb/tb_prime_test_scheduler.sv
// Randomized + directed bench for prime_test_scheduler against a plain arithmetic reference.
module tb_prime_test_scheduler;
   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   model_last = NUM_REQ - 1;
   logic [WIDTH-1:0] nums [NUM_REQ];

   always #5 clk = ~clk;

   prime_test_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

   prime_test_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Primality by plain divisor search up to sqrt(n).
   function automatic bit ref_prime(input longint unsigned n);
      if (n < 2) return 1'b0;
      for (longint unsigned d = 2; d * d <= n; d++)
         if (n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   // Number of candidate pairs examined before a decision (0 for trivial operands).
   function automatic int ref_k(input longint unsigned n);
      int k;
      if (n <= 3 || n % 2 == 0 || n % 3 == 0) return 0;
      k = 0;
      for (longint unsigned c = 5; ; c += 6) begin
         k++;
         if (c * c > n) break;
         if (n % c == 0 || n % (c + 2) == 0) break;
      end
      return k;
   endfunction

   function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
      for (int o = 1; o <= NUM_REQ; o++)
         if (mask[(last + o) % NUM_REQ]) return (last + o) % NUM_REQ;
      return -1;
   endfunction

   task automatic drive_reqs(input logic [NUM_REQ-1:0] mask);
      bus.req_valid = mask;
      for (int r = 0; r < NUM_REQ; r++) bus.req_num[r*WIDTH +: WIDTH] = nums[r];
   endtask

   // One full transaction; called #1 after a rising edge while the DUT is idle.
   task automatic do_txn(input logic [NUM_REQ-1:0] mask, input int hold,
                         input bit early_ready, input string tag);
      int g, lat, k;
      logic [WIDTH-1:0] n;
      bit exp_p;
      g = rr_pick(mask, model_last);
      drive_reqs(mask);
      bus.rsp_ready = early_ready;
      #1;
      chk({tag, "_ready"}, 64'(bus.req_ready), 64'(1) << g);
      @(posedge clk); #1;
      bus.req_valid = '0;
      model_last = g;
      n     = nums[g];
      exp_p = ref_prime(64'(n));
      k     = ref_k(64'(n));
      lat   = 1;
      while (!bus.rsp_valid && lat < 25000) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(2 + k));
      chk({tag, "_id"}, 64'(bus.rsp_id), 64'(g));
      chk({tag, "_num"}, 64'(bus.rsp_num), 64'(n));
      chk({tag, "_prime"}, 64'(bus.rsp_is_prime), 64'(exp_p));
`ifdef PRIME_CYCLE_COUNT_EN
      chk({tag, "_cycles"}, 64'(bus.rsp_cycles), 64'(k));
`endif
      if (!early_ready) begin
         bus.req_valid = '1;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
            chk({tag, "_hold_num"}, 64'(bus.rsp_num), 64'(n));
            chk({tag, "_hold_id"}, 64'(bus.rsp_id), 64'(g));
            chk({tag, "_hold_prime"}, 64'(bus.rsp_is_prime), 64'(exp_p));
            chk({tag, "_hold_noready"}, 64'(bus.req_ready), 64'd0);
         end
         bus.req_valid = '0;
         bus.rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk({tag, "_released"}, 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = '0;
      bus.req_num   = '0;
      bus.rsp_ready = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) nums[r] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("rst_rsp_num", 64'(bus.rsp_num), 64'd0);
      chk("rst_rsp_prime", 64'(bus.rsp_is_prime), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      nums[0] = 32'd29;
      do_txn(4'b0001, 10, 1'b0, "p29");

      foreach (nums[r]) nums[r] = 32'd7;
      begin
         logic [WIDTH-1:0] triv_ops [6];
         triv_ops = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd9};
         for (int t = 0; t < 6; t++) begin
            nums[2] = triv_ops[t];
            do_txn(4'b0100, t % 2, t[0], $sformatf("triv%0d", triv_ops[t]));
         end
      end

      nums[1] = 32'd25;
      do_txn(4'b0010, 0, 1'b0, "c25");
      nums[0] = 32'hFFFF_FFFF;
      do_txn(4'b0001, 1, 1'b0, "max_u32");
      nums[3] = 32'd4294967291;
      do_txn(4'b1000, 1, 1'b1, "max_prime");

      for (int t = 0; t < 5; t++) begin
         for (int r = 0; r < NUM_REQ; r++) nums[r] = 32'($urandom_range(0, 3000));
         do_txn(4'b1111, 0, 1'b1, $sformatf("rr%0d", t));
      end

      // Reset in the middle of a long TEST run discards the operand.
      nums[0] = 32'd1000003;
      drive_reqs(4'b0001);
      #1;
      chk("rstmid_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      repeat (20) @(posedge clk);
      #1;
      chk("rstmid_busy", 64'(bus.rsp_valid), 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_last = NUM_REQ - 1;
      chk("rstmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rstmid_req_ready", 64'(bus.req_ready), 64'd0);
      do_txn(4'b0001, 2, 1'b0, "after_rst");

      for (int t = 0; t < 40; t++) begin
         logic [NUM_REQ-1:0] mask;
         mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         for (int r = 0; r < NUM_REQ; r++)
            nums[r] = ($urandom_range(0, 9) < 7) ? 32'($urandom_range(0, 5000))
                                                 : 32'($urandom_range(0, 300000));
         do_txn(mask, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/prime_test_scheduler.md
# prime_test_scheduler

Shares one iterative trial-division prime engine among NUM_REQ requesters. A round-robin arbiter grants one requester at a time. The engine tests the granted number over multiple cycles using the 6k±1 candidate sequence. The block returns a tagged result over a valid/ready response channel. It sits between the number-producing clients and any consumer of primality results, and replaces per-client combinational checkers with one shared sequential datapath.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 32, operand width in bits
- ID_W, $clog2(NUM_REQ), requester tag width (derived)
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_num  input  NUM_REQ*WIDTH  packed operands; requester k occupies bits [k*WIDTH +: WIDTH]
- req_ready  output  NUM_REQ  one-hot grant/accept, at most one bit set
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  index of the requester that owns the result
- rsp_num  output  WIDTH  operand that was tested
- rsp_is_prime  output  1  1 = prime, 0 = not prime

## Operation
- States: IDLE, LOAD, TEST, DONE.
- IDLE:
  - req_ready[g] = 1 for the grant g only. g is the first index with req_valid set, searching from (last_grant+1) mod NUM_REQ.
  - req_ready is combinational from req_valid and last_grant.
  - On req_valid[g]&req_ready[g]: latch num, id=g, last_grant=g, go to LOAD.
- LOAD resolves the trivial cases, then goes to DONE:
  - num ≤ 1 → not prime
  - num = 2 or 3 → prime
  - num divisible by 2 or by 3 → not prime
- LOAD sets i=5 and goes to TEST for every other operand.
- TEST (one candidate pair per cycle):
  - i*i > num → prime, go to DONE.
  - Else if num%i==0 or num%(i+2)==0 → not prime, go to DONE.
  - Else i += 6 and stay in TEST.
- i*i is computed at 2*WIDTH bits so it cannot wrap. i is WIDTH+1 bits.
- DONE: rsp_valid=1. rsp_id, rsp_num and rsp_is_prime stay stable until rsp_valid&rsp_ready, then go to IDLE.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE
  - req_ready=0 until the first IDLE evaluation with a valid request
  - rsp_valid=0, rsp_id=0, rsp_num=0, rsp_is_prime=0
  - last_grant=NUM_REQ-1, so requester 0 wins first
- Latency counts from the accept edge E:
  - trivial case: rsp_valid rises at E+2
  - TEST case with k TEST cycles: rsp_valid rises at E+2+k
- Example: num=29 gives k=2, so rsp_valid rises at E+4.
- Throughput: a new grant is possible no earlier than one cycle after the response handshake. When DONE→IDLE happens, the next accept is at E'+1 at the earliest.
- If rsp_ready is already high when rsp_valid rises, the handshake completes in that same cycle.
- Reset asserted in any state:
  - the next state is IDLE and the in-flight operand is discarded
  - rsp_valid drops on the next edge; no partial result is emitted
- A requester may drop req_valid before it is granted. It loses the slot without error.
- Worst case k for WIDTH=32 is about 10923 cycles, bounded by sqrt(2^32)/6.

## Configuration
- PRIME_CYCLE_COUNT_EN defined:
  - adds output rsp_cycles [WIDTH-1:0], the number of TEST cycles spent on the returned operand (0 for trivial cases)
  - the counter clears in LOAD and saturates at all-ones
  - rsp_cycles resets to 0 and is held with the other rsp fields
- PRIME_CYCLE_COUNT_EN undefined: no counter and no port. All other behaviour is identical.

## Structure
- Package prime_sched_pkg holds:
  - the state enum (IDLE, LOAD, TEST, DONE)
  - default WIDTH, the candidate start value 5 and step 6
  - the function for the trivial-case result
- Sub-module prime_trial_engine holds the i register, the two modulo checks, the i*i compare and the done/prime flags, with start/done handshake.
- The scheduler owns the arbiter, the FSM and the response registers.

## Test plan
- Reset, then single request req_num[0]=29 → req_ready=4'b0001, rsp_valid at E+4, rsp_id=0, rsp_is_prime=1.
- Trivial operands 0, 1, 2, 3, 4, 9 on requester 2 → responses 0, 0, 1, 1, 0, 0, each at E+2.
- Composite 25 → not prime at E+3. Composite 4294967291*? skipped; largest 32-bit prime 4294967291 → prime. 4294967295 → not prime. Neither may wrap i*i.
- All four requesters continuously valid → grants in order 0, 1, 2, 3, 0. No requester is granted twice while another valid one waits.
- rsp_ready held low for 10 cycles → rsp_valid and the rsp fields stay stable. No req_ready asserts until the handshake.
- rst pulsed during TEST for num=1000003 → next cycle rsp_valid=0 and IDLE. A subsequent request to requester 0 is served normally.
